// File: rtl/mux2_arb.sv
// -----------------------------------------------------------------------------
// mux2_arb
//
// Two-requester round-robin arbiter driving a registered 2:1 data mux.
// A requester holds its level request for the whole time it owns the
// resource. The datapath select follows the owner, and the selected data is
// registered one cycle after every owned cycle.
//
// Optional feature (compile-time macro MUX2_ARB_TIMEOUT_EN):
//   When defined, a hold counter limits continuous ownership to HOLD_MAX+1
//   cycles while the other requester is waiting. The arbiter then forces a
//   hand-over and pulses TOUT. When undefined, the owner keeps the resource
//   until it releases it, TOUT is tied low and HOLD_MAX has no effect.
//
// Parameters
//   WIDTH     data width of IN0 / IN1 / Q
//   HOLD_MAX  hold-counter saturation value, legal range 1..255
//
// Ports
//   CLK         in   clock, all state updates on the rising edge
//   RN          in   asynchronous active-low reset
//   REQ0, REQ1  in   level requests from requester 0 / 1
//   IN0, IN1    in   data from requester 0 / 1
//   GNT0, GNT1  out  grants, decoded from the registered state (one-hot or 0)
//   S           out  mux select, 0 = IN0, 1 = IN1
//   Q           out  registered selected data
//   QV          out  Q valid (high the cycle after any owned cycle)
//   TOUT        out  one-cycle forced hand-over pulse
// -----------------------------------------------------------------------------
module mux2_arb #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             S,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic             TOUT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Reject out-of-range hold limits at elaboration time.
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("mux2_arb: HOLD_MAX must lie in 1..255");
    end

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             s_q, s_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qv_q, qv_d;
    logic             forced;
    logic             owned;
    logic             changing;

`ifdef MUX2_ARB_TIMEOUT_EN
    localparam logic [7:0] HoldMaxC = 8'(HOLD_MAX);

    logic [7:0] hcnt_q, hcnt_d;
    logic       tout_q, tout_d;
    logic       expired;

    assign expired = (hcnt_q == HoldMaxC);
`endif

    assign owned    = (state_q != IDLE);
    assign changing = (state_d != state_q);

    // Next-state logic. last_q remembers who was served most recently, so a
    // contest from IDLE goes to the other requester (last_q resets to 1 so
    // requester 0 wins the very first contest). A releasing owner hands over
    // straight to a waiting requester without passing through IDLE.
    always_comb begin
        state_d = state_q;
        forced  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (REQ0 && REQ1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (REQ0) begin
                    state_d = OWN0;
                end else if (REQ1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!REQ0) begin
                    state_d = REQ1 ? OWN1 : IDLE;
                end
`ifdef MUX2_ARB_TIMEOUT_EN
                else if (REQ1 && expired) begin
                    state_d = OWN1;
                    forced  = 1'b1;
                end
`endif
            end
            OWN1: begin
                if (!REQ1) begin
                    state_d = REQ0 ? OWN0 : IDLE;
                end
`ifdef MUX2_ARB_TIMEOUT_EN
                else if (REQ0 && expired) begin
                    state_d = OWN0;
                    forced  = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Select and last-served flag only move on the edge that enters an owned
    // state; in IDLE the select keeps pointing at the previous owner.
    // The data register samples through the current select on every owned
    // cycle, giving one cycle of input-to-Q latency.
    always_comb begin
        last_d = last_q;
        s_d    = s_q;
        if (changing && state_d == OWN0) begin
            last_d = 1'b0;
            s_d    = 1'b0;
        end else if (changing && state_d == OWN1) begin
            last_d = 1'b1;
            s_d    = 1'b1;
        end
        q_d  = owned ? (s_q ? IN1 : IN0) : q_q;
        qv_d = owned;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            s_q     <= 1'b0;
            q_q     <= '0;
            qv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            s_q     <= s_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
        end
    end

`ifdef MUX2_ARB_TIMEOUT_EN
    // Hold counter: cleared whenever the state changes, counts owned cycles
    // and sticks at the limit. The forced-hand-over flag is registered so the
    // TOUT pulse lines up with the first cycle of the new owner's grant.
    always_comb begin
        hcnt_d = hcnt_q;
        tout_d = forced;
        if (changing) begin
            hcnt_d = 8'd0;
        end else if (owned && !expired) begin
            hcnt_d = hcnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            hcnt_q <= 8'd0;
            tout_q <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            tout_q <= tout_d;
        end
    end

    assign TOUT = tout_q;
`else
    assign TOUT = 1'b0;

    logic unusedForced;
    assign unusedForced = forced;
`endif

    assign GNT0 = (state_q == OWN0);
    assign GNT1 = (state_q == OWN1);
    assign S    = s_q;
    assign Q    = q_q;
    assign QV   = qv_q;

endmodule

// File: tb/tb_mux2_arb.sv
// -----------------------------------------------------------------------------
// tb_mux2_arb
//
// Directed bench for mux2_arb (WIDTH=8, HOLD_MAX=3). Expected values are
// hand-computed; the forced hand-over expectations follow the
// MUX2_ARB_TIMEOUT_EN macro so the bench works with either build.
// -----------------------------------------------------------------------------
module tb_mux2_arb;

   logic       clock;
   logic       rn;
   logic       req0, req1;
   logic [7:0] in0, in1;
   logic       gnt0, gnt1, sel, qv, tout;
   logic [7:0] q;

   int total = 0;
   int bad   = 0;

`ifdef MUX2_ARB_TIMEOUT_EN
   localparam bit TimeoutOn = 1'b1;
`else
   localparam bit TimeoutOn = 1'b0;
`endif

   mux2_arb #(
      .WIDTH   (8),
      .HOLD_MAX(3)
   ) dut (
      .CLK (clock),
      .RN  (rn),
      .REQ0(req0),
      .REQ1(req1),
      .IN0 (in0),
      .IN1 (in1),
      .GNT0(gnt0),
      .GNT1(gnt1),
      .S   (sel),
      .Q   (q),
      .QV  (qv),
      .TOUT(tout)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Drives the request and data inputs in one go.
   task automatic applyStimulus(input logic r0, input logic r1,
                                input logic [7:0] d0, input logic [7:0] d1);
      req0 = r0;
      req1 = r1;
      in0  = d0;
      in1  = d1;
   endtask

   // Compares one observed value with its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks the whole output set against one expected vector.
   task automatic checkAll(input string tag, input logic g0, input logic g1,
                           input logic s, input logic [7:0] qx,
                           input logic v, input logic t);
      checkOutput({tag, ".GNT0"}, 32'(gnt0), 32'(g0));
      checkOutput({tag, ".GNT1"}, 32'(gnt1), 32'(g1));
      checkOutput({tag, ".S"},    32'(sel),  32'(s));
      checkOutput({tag, ".Q"},    32'(q),    32'(qx));
      checkOutput({tag, ".QV"},   32'(qv),   32'(v));
      checkOutput({tag, ".TOUT"}, 32'(tout), 32'(t));
   endtask

   // Advances to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Directed sequence; every step below is one clock unless noted.
   initial begin
      rn = 1'b1;
      applyStimulus(1'b1, 1'b1, 8'h11, 8'h22);
      #2 rn = 1'b0;
      #1;
      checkAll("reset_async", 0, 0, 0, 8'h00, 0, 0);
      tick();
      tick();
      checkAll("reset_held", 0, 0, 0, 8'h00, 0, 0);

      // Release reset with both requests pending: requester 0 wins.
      rn = 1'b1;
      tick();
      checkAll("rr_first_gnt0", 1, 0, 0, 8'h00, 0, 0);
      tick();
      checkAll("own0_q_in0", 1, 0, 0, 8'h11, 1, 0);

      // Both release: back to IDLE, the last owned cycle still yields QV.
      applyStimulus(1'b0, 1'b0, 8'h11, 8'h22);
      tick();
      checkAll("own0_release", 0, 0, 0, 8'h11, 1, 0);
      tick();
      checkAll("idle_qv_low", 0, 0, 0, 8'h11, 0, 0);

      // Second contest goes to requester 1.
      applyStimulus(1'b1, 1'b1, 8'h11, 8'h22);
      tick();
      checkAll("rr_second_gnt1", 0, 1, 1, 8'h11, 0, 0);

      // Owner 1 releases with nobody waiting: select stays at 1, Q holds.
      applyStimulus(1'b0, 1'b0, 8'h11, 8'h22);
      tick();
      checkAll("own1_release", 0, 0, 1, 8'h22, 1, 0);
      applyStimulus(1'b0, 1'b0, 8'h77, 8'h88);
      tick();
      checkAll("idle_s_holds", 0, 0, 1, 8'h22, 0, 0);

      // Direct hand-over 0 -> 1 with no IDLE bubble.
      applyStimulus(1'b1, 1'b0, 8'hA5, 8'h3C);
      tick();
      checkAll("own0_enter", 1, 0, 0, 8'h22, 0, 0);
      applyStimulus(1'b0, 1'b1, 8'hA5, 8'h3C);
      tick();
      checkAll("handover_q_a5", 0, 1, 1, 8'hA5, 1, 0);
      tick();
      checkAll("handover_q_3c", 0, 1, 1, 8'h3C, 1, 0);

      // Reset between edges while owning: everything drops without a clock.
      #3 rn = 1'b0;
      #1;
      checkAll("reset_mid_own1", 0, 0, 0, 8'h00, 0, 0);
      applyStimulus(1'b1, 1'b1, 8'h5A, 8'hC3);
      tick();
      checkAll("reset_mid_held", 0, 0, 0, 8'h00, 0, 0);

      // Both requests held continuously from reset release.
      rn = 1'b1;
      tick();
      checkAll("hold_c1", 1, 0, 0, 8'h00, 0, 0);
      tick();
      checkAll("hold_c2", 1, 0, 0, 8'h5A, 1, 0);
      tick();
      checkAll("hold_c3", 1, 0, 0, 8'h5A, 1, 0);
      tick();
      checkAll("hold_c4", 1, 0, 0, 8'h5A, 1, 0);
      tick();
      if (TimeoutOn) begin
         checkAll("hold_forced", 0, 1, 1, 8'h5A, 1, 1);
      end else begin
         checkAll("hold_kept", 1, 0, 0, 8'h5A, 1, 0);
      end
      tick();
      if (TimeoutOn) begin
         checkAll("hold_after_forced", 0, 1, 1, 8'hC3, 1, 0);
      end else begin
         checkAll("hold_kept_more", 1, 0, 0, 8'h5A, 1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
